// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding selects, load-use
// stall, branch flush, MDU sequencing and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_use_rs,
   input  logic             ID_use_rt,
   input  logic             ID_mdu_start,
   input  logic             ID_mdu_div,
   input  logic [4:0]       EX_WriteReg,
   input  logic             EX_RegWrite,
   input  logic             EX_MemtoReg,
   input  logic [4:0]       MEM_WriteReg,
   input  logic             MEM_RegWrite,
   input  logic             EX_branch_taken,
   output logic             stall,
   output logic             stall2,
   output logic             flush,
   output logic [1:0]       ID_FA,
   output logic [1:0]       ID_FB,
   output logic             mdu_go,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            load_use;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] ex_wr,
      input logic       ex_we,
      input logic       ex_ld,
      input logic [4:0] mem_wr,
      input logic       mem_we
   );
      if (ex_we && ex_wr != 5'd0 && ex_wr == src && !ex_ld)
         return 2'b01;
      else if (mem_we && mem_wr != 5'd0 && mem_wr == src)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      load_use = EX_MemtoReg && EX_RegWrite && (EX_WriteReg != 5'd0) &&
                 ((ID_use_rs && EX_WriteReg == ID_rs) ||
                  (ID_use_rt && EX_WriteReg == ID_rt));
      flush    = EX_branch_taken && !reset;
      stall    = load_use && !EX_branch_taken && (state == IDLE) && !reset;
      ID_FA    = reset ? 2'b00 : fwd_sel(ID_rs, EX_WriteReg, EX_RegWrite, EX_MemtoReg,
                                         MEM_WriteReg, MEM_RegWrite);
      ID_FB    = reset ? 2'b00 : fwd_sel(ID_rt, EX_WriteReg, EX_RegWrite, EX_MemtoReg,
                                         MEM_WriteReg, MEM_RegWrite);
      mdu_go   = (state == IDLE) && ID_mdu_start && !stall && !EX_branch_taken && !reset;
      stall2   = (state == RUN);
      mdu_busy = (state == RUN);
      mdu_done = (state == DONE);
   end

   // A branch resolved in EX while RUN squashes the held op, so it wins over completion.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (mdu_go) begin
               state_nxt = RUN;
               cnt_nxt   = ID_mdu_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end
         end
         RUN: begin
            if (EX_branch_taken)
               state_nxt = IDLE;
            else if (cnt == '0)
               state_nxt = DONE;
            else
               cnt_nxt = cnt - CW'(1);
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         stall_cycles <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if ((stall || stall2) && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic checked against
// a cycle-count model of the hazard rules (MULT=4, DIV=32, CNT_W=4).
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MULT = 4;
   localparam int unsigned DIV  = 32;
   localparam int unsigned CW   = 4;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [4:0]    ID_rs, ID_rt, EX_WriteReg, MEM_WriteReg;
   logic          ID_use_rs, ID_use_rt, ID_mdu_start, ID_mdu_div;
   logic          EX_RegWrite, EX_MemtoReg, MEM_RegWrite, EX_branch_taken;
   logic          stall, stall2, flush, mdu_go, mdu_busy, mdu_done;
   logic [1:0]    ID_FA, ID_FB;
   logic [CW-1:0] stall_cycles;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Model state: RUN cycles still owed, a pending done pulse, stall count.
   int unsigned m_left = 0;
   bit          m_done = 0;
   int unsigned m_cnt  = 0;

   pipeline_hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
      .ID_mdu_start(ID_mdu_start), .ID_mdu_div(ID_mdu_div),
      .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
      .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite),
      .EX_branch_taken(EX_branch_taken),
      .stall(stall), .stall2(stall2), .flush(flush), .ID_FA(ID_FA), .ID_FB(ID_FB),
      .mdu_go(mdu_go), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] r);
      if (EX_RegWrite && !EX_MemtoReg && EX_WriteReg != 0 && EX_WriteReg == r) return 2'b01;
      if (MEM_RegWrite && MEM_WriteReg != 0 && MEM_WriteReg == r) return 2'b10;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
      ID_mdu_start = 0; ID_mdu_div = 0;
      EX_WriteReg = 0; EX_RegWrite = 0; EX_MemtoReg = 0;
      MEM_WriteReg = 0; MEM_RegWrite = 0; EX_branch_taken = 0;
   endtask

   task automatic rand_inputs();
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      ID_use_rs    = 1'($urandom);
      ID_use_rt    = 1'($urandom);
      ID_mdu_start = ($urandom_range(0, 3) == 0);
      ID_mdu_div   = ($urandom_range(0, 5) == 0);
      EX_WriteReg  = 5'($urandom_range(0, 3));
      EX_RegWrite  = 1'($urandom);
      EX_MemtoReg  = ($urandom_range(0, 2) == 0);
      MEM_WriteReg = 5'($urandom_range(0, 3));
      MEM_RegWrite = 1'($urandom);
      EX_branch_taken = ($urandom_range(0, 7) == 0);
   endtask

   // Called just after a falling edge with inputs applied; returns after the next falling edge.
   task automatic step();
      bit idle, lu, e_stall, e_go, busy;
      #1;
      idle = (m_left == 0) && !m_done;
      busy = (m_left != 0);
      lu = EX_MemtoReg && EX_RegWrite && EX_WriteReg != 0 &&
           ((ID_use_rs && EX_WriteReg == ID_rs) || (ID_use_rt && EX_WriteReg == ID_rt));
      e_stall = lu && !EX_branch_taken && idle;
      e_go    = idle && ID_mdu_start && !e_stall && !EX_branch_taken;
      check("ID_FA", 32'(ID_FA), 32'(ref_fwd(ID_rs)));
      check("ID_FB", 32'(ID_FB), 32'(ref_fwd(ID_rt)));
      check("flush", 32'(flush), 32'(EX_branch_taken));
      check("stall", 32'(stall), 32'(e_stall));
      check("stall2", 32'(stall2), 32'(busy));
      check("mdu_busy", 32'(mdu_busy), 32'(busy));
      check("mdu_done", 32'(mdu_done), 32'(m_done));
      check("mdu_go", 32'(mdu_go), 32'(e_go));
      check("stall_cycles", 32'(stall_cycles), m_cnt);
      @(posedge clock);
      if ((e_stall || busy) && m_cnt < CMAX) m_cnt++;
      if (busy) begin
         if (EX_branch_taken) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) m_done = 1;
         end
      end else if (m_done) m_done = 0;
      else if (e_go) m_left = ID_mdu_div ? DIV : MULT;
      @(negedge clock);
   endtask

   // Reset raised mid-cycle with arbitrary inputs; every output must drop at once.
   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_stall", 32'(stall), 0);
      check("rst_stall2", 32'(stall2), 0);
      check("rst_flush", 32'(flush), 0);
      check("rst_FA", 32'(ID_FA), 0);
      check("rst_FB", 32'(ID_FB), 0);
      check("rst_go", 32'(mdu_go), 0);
      check("rst_busy", 32'(mdu_busy), 0);
      check("rst_done", 32'(mdu_done), 0);
      check("rst_cnt", 32'(stall_cycles), 0);
      m_left = 0; m_done = 0; m_cnt = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int unsigned base;
      clear_inputs();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      EX_WriteReg = 5; EX_RegWrite = 1; ID_rs = 5; EX_branch_taken = 1; ID_mdu_start = 1;
      async_reset();

      // Forwarding: EX over MEM, MEM when EX misses, r0 never forwards.
      clear_inputs();
      EX_WriteReg = 5; EX_RegWrite = 1; MEM_WriteReg = 5; MEM_RegWrite = 1; ID_rs = 5;
      #1 check("fwd_ex", 32'(ID_FA), 32'b01);
      step();
      EX_WriteReg = 6;
      #1 check("fwd_mem", 32'(ID_FA), 32'b10);
      step();
      EX_WriteReg = 0; MEM_WriteReg = 0; ID_rs = 0; ID_rt = 0;
      #1 check("fwd_r0", 32'(ID_FA), 32'b00);
      step();

      // Load-use on rt, with and without use_rt.
      clear_inputs();
      EX_WriteReg = 8; EX_RegWrite = 1; EX_MemtoReg = 1; ID_rt = 8; ID_use_rt = 1;
      #1 check("lu_hit", 32'(stall), 1);
      step();
      ID_use_rt = 0;
      #1 check("lu_nouse", 32'(stall), 0);
      step();

      // Multiply: go, four stall2 cycles, done, no relaunch.
      clear_inputs();
      base = m_cnt;
      ID_mdu_start = 1;
      step();
      for (int unsigned i = 0; i < MULT + 1; i++) step();
      check("mul_stall_cnt", 32'(stall_cycles), base + MULT);
      ID_mdu_start = 0;
      step();

      // Divide aborted by reset in RUN, then a clean multiply.
      ID_mdu_start = 1; ID_mdu_div = 1;
      step();
      ID_mdu_start = 0;
      for (int unsigned i = 0; i < 10; i++) step();
      async_reset();
      ID_mdu_start = 1; ID_mdu_div = 0;
      step();
      ID_mdu_start = 0;
      for (int unsigned i = 0; i < MULT + 2; i++) step();

      // Branch collides with load-use and MDU start.
      EX_WriteReg = 8; EX_RegWrite = 1; EX_MemtoReg = 1; ID_rs = 8; ID_use_rs = 1;
      ID_mdu_start = 1; EX_branch_taken = 1;
      #1 check("col_go", 32'(mdu_go), 0);
      step();
      EX_branch_taken = 0; ID_mdu_start = 0;
      step();

      // Saturation: sustained load-use stall.
      for (int unsigned i = 0; i < 20; i++) step();
      check("sat", 32'(stall_cycles), CMAX);

      // Random traffic with occasional asynchronous reset.
      clear_inputs();
      for (int unsigned i = 0; i < 3000; i++) begin
         rand_inputs();
         if ($urandom_range(0, 99) == 0) async_reset();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the five-stage pipeline. It generates the stall and stall2 signals, so the ID/EX register inserts bubbles while they are high. It also generates the IF/ID flush and the ID-stage forwarding selects ID_FA/ID_FB, which are registered into EX.
It sequences the multi-cycle multiply/divide unit (MDU) with a small FSM and latency counter, and keeps a saturating stall-cycle counter for performance checks.

Parameters:
MULT_CYCLES, 4, MDU busy cycles for multiply (>=1)
DIV_CYCLES, 32, MDU busy cycles for divide (>=1)
CNT_W, 16, width of stall_cycles counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ID_rs  in  5  source register rs of instruction in ID
ID_rt  in  5  source register rt of instruction in ID
ID_use_rs  in  1  ID instruction reads rs
ID_use_rt  in  1  ID instruction reads rt
ID_mdu_start  in  1  ID instruction is an MDU op
ID_mdu_div  in  1  1 = divide, 0 = multiply (valid with ID_mdu_start)
EX_WriteReg  in  5  destination of instruction in EX
EX_RegWrite  in  1  EX instruction writes register file
EX_MemtoReg  in  1  EX instruction is a load
MEM_WriteReg  in  5  destination of instruction in MEM
MEM_RegWrite  in  1  MEM instruction writes register file
EX_branch_taken  in  1  branch/jump resolved taken in EX
stall  out  1  load-use stall: freeze PC and IF/ID, bubble ID/EX
stall2  out  1  MDU stall: freeze PC and IF/ID, bubble ID/EX
flush  out  1  squash IF/ID contents
ID_FA  out  2  rs operand select: 00 reg file, 01 EX result, 10 MEM result
ID_FB  out  2  rt operand select, same encoding
mdu_go  out  1  one-cycle pulse: launch MDU
mdu_busy  out  1  MDU running
mdu_done  out  1  one-cycle pulse: MDU result valid, held instruction released
stall_cycles  out  CNT_W  saturating count of cycles with stall|stall2

Behaviour:
Reset (async, any time, including mid-MDU):
- FSM goes to IDLE, latency counter 0, stall_cycles 0.
- stall2, mdu_go, mdu_busy, mdu_done all 0.
- While reset is high, stall, flush, ID_FA and ID_FB are forced to 0/00.

Forwarding (combinational, per operand X in {rs, rt}):
- 01 if EX_RegWrite && EX_WriteReg!=0 && EX_WriteReg==ID_X && !EX_MemtoReg.
- Else 10 if MEM_RegWrite && MEM_WriteReg!=0 && MEM_WriteReg==ID_X.
- Else 00. EX match has priority over MEM match. Register 0 never forwards.

Load-use (combinational):
- stall=1 if EX_MemtoReg && EX_RegWrite && EX_WriteReg!=0 && ((ID_use_rs && EX_WriteReg==ID_rs) || (ID_use_rt && EX_WriteReg==ID_rt)).
- Forced to 0 when flush=1: the dependent instruction is squashed.
- Forced to 0 when the FSM is not in IDLE.

flush (combinational):
- flush = EX_branch_taken.

FSM IDLE / RUN / DONE:
- IDLE: accept a start when ID_mdu_start && !stall && !flush. On accept:
  - pulse mdu_go;
  - load counter with (ID_mdu_div ? DIV_CYCLES : MULT_CYCLES) - 1;
  - go to RUN.
- RUN: mdu_busy=1, stall2=1.
  - If counter==0, go to DONE; otherwise decrement.
  - If EX_branch_taken is seen, abort to IDLE with no mdu_done.
- DONE: mdu_done=1, stall2=0; the held instruction advances this cycle.
  - ID_mdu_start is ignored in DONE (no re-launch of the same instruction).
  - Next state is IDLE.
- An MDU op therefore holds ID for exactly N cycles of stall2, then releases.
- Back-to-back MDU ops: the second launches from IDLE, one cycle after DONE.
- stall2 is derived from registered state only, with no combinational path from inputs.

stall_cycles:
- Increments on each clock with stall|stall2.
- Holds at 2^CNT_W-1 (saturates, no wrap).

Simultaneous events:
- Branch + load-use: flush=1, stall=0.
- Branch + MDU start in IDLE: no launch.
- Load-use + MDU start: no launch; retried next cycle once stall drops.

Test Plan:
- Forwarding: EX writes r5 (not load), MEM writes r5, ID_rs=5 -> ID_FA=01. Same, but EX_WriteReg=6 -> ID_FA=10. Writes to r0 -> 00.
- Load-use: EX load to r8, ID_use_rt=1, ID_rt=8 -> stall=1 for that cycle. Same with ID_use_rt=0 -> stall=0.
- Multiply: ID_mdu_start=1, ID_mdu_div=0, MULT_CYCLES=4 -> mdu_go at cycle 0, then stall2=1 for 4 cycles. Next cycle: mdu_done=1, stall2=0, no re-launch. stall_cycles increases by 4.
- Divide abort: start divide, then reset high at RUN cycle 10 -> all outputs 0 immediately, FSM IDLE. After reset, a new multiply runs a full 4 cycles.
- Branch collision: EX_branch_taken=1 with a load-use hazard and ID_mdu_start=1 -> flush=1, stall=0, mdu_go=0, FSM stays IDLE.
- Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cycles stops at 15.
